// File: rtl/rnd_en_gate_mc_if.sv
// Bus between the random enable gate and its user: config, seeding, per-channel
// enable requests in, gated enables and status out.
interface rnd_en_gate_mc_if #(
  parameter int CH     = 4,
  parameter int LFSR_W = 16
);
  logic              cfg_en;
  logic [7:0]        cfg_thresh;
  logic              seed_ld;
  logic [LFSR_W-1:0] seed;
  logic [CH-1:0]     en_i;
  logic [CH-1:0]     rdy_o;
  logic [CH-1:0]     en_o;
  logic              stall_o;
  logic [CH-1:0]     ovf_o;
  logic [15:0]       stall_cnt_o;

  modport master (
    output cfg_en, cfg_thresh, seed_ld, seed, en_i,
    input  rdy_o, en_o, stall_o, ovf_o, stall_cnt_o
  );

  modport slave (
    input  cfg_en, cfg_thresh, seed_ld, seed, en_i,
    output rdy_o, en_o, stall_o, ovf_o, stall_cnt_o
  );
endinterface

// File: rtl/rnd_en_gate_mc.sv
// Randomly stalls per-channel enables using an LFSR, queueing delayed requests
// in a small per-channel backlog counter; stall runs are bounded by MAX_STALL.
module rnd_en_gate_mc #(
  parameter int CH        = 4,
  parameter int LFSR_W    = 16,
  parameter int MAX_STALL = 3,
  parameter int PEND_MAX  = 4
) (
  input  logic clk,
  input  logic rst,
  rnd_en_gate_mc_if.slave bus
);
  localparam int PW = 4;
  localparam int CW = 4;

  logic [LFSR_W-1:0] lfsr_reg;
  logic [LFSR_W-1:0] lfsr_next;
  logic              fb;
  logic [CW-1:0]     consec_reg;
  logic [15:0]       stall_cnt_reg;
  logic [CH-1:0]     ovf_reg;
  logic [CH-1:0]     rdy;
  logic [CH-1:0]     acc;
  logic [CH-1:0]     iss;
  logic              stall_raw;
  logic              stall;

  generate
    if (LFSR_W == 32) begin : g_taps32
      assign fb = lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0];
    end else begin : g_taps16
      assign fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
    end
  endgenerate

  // A zero seed would lock the LFSR, so it is replaced by 1.
  always_comb begin
    lfsr_next = {lfsr_reg[LFSR_W-2:0], fb};
    if (bus.seed_ld) begin
      lfsr_next = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
    end
  end

  assign stall_raw = bus.cfg_en & (lfsr_reg[7:0] < bus.cfg_thresh);
  assign stall     = stall_raw & (consec_reg < CW'(MAX_STALL));

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg      <= '1;
      consec_reg    <= '0;
      stall_cnt_reg <= '0;
      ovf_reg       <= '0;
    end else begin
      lfsr_reg   <= lfsr_next;
      consec_reg <= stall ? consec_reg + CW'(1) : '0;
      if (stall && stall_cnt_reg != 16'hFFFF) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
      ovf_reg <= ovf_reg | (bus.en_i & ~rdy);
    end
  end

  // Per-channel backlog: accept and issue in the same cycle cancel out.
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      logic [PW-1:0] pend_reg;

      assign rdy[gi] = pend_reg < PW'(PEND_MAX);
      assign acc[gi] = bus.en_i[gi] & rdy[gi];
      assign iss[gi] = ~stall & ((pend_reg != '0) | acc[gi]);

      always_ff @(posedge clk) begin
        if (rst) begin
          pend_reg <= '0;
        end else begin
          pend_reg <= pend_reg + {{(PW-1){1'b0}}, acc[gi]} - {{(PW-1){1'b0}}, iss[gi]};
        end
      end
    end
  endgenerate

  assign bus.rdy_o       = rdy;
  assign bus.en_o        = iss;
  assign bus.stall_o     = stall;
  assign bus.ovf_o       = ovf_reg;
  assign bus.stall_cnt_o = stall_cnt_reg;
endmodule

// File: tb/tb_rnd_en_gate_mc.sv
// Randomized and directed checks of rnd_en_gate_mc against a cycle-level
// behavioural model built from the stall/backlog rules.
module tb_rnd_en_gate_mc;
  localparam int CH        = 4;
  localparam int LFSR_W    = 16;
  localparam int MAX_STALL = 3;
  localparam int PEND_MAX  = 4;

  logic clk;
  logic rst;

  rnd_en_gate_mc_if #(.CH(CH), .LFSR_W(LFSR_W)) bus ();

  rnd_en_gate_mc #(
    .CH(CH), .LFSR_W(LFSR_W), .MAX_STALL(MAX_STALL), .PEND_MAX(PEND_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // model state
  logic [15:0] m_lfsr;
  int          m_run;
  int          m_pend [CH];
  logic [CH-1:0] m_ovf;
  int          m_cnt;

  // observation statistics
  int   run_obs, max_run_obs, n_stall_obs, n_iss0, n_acc0;
  logic saw_full;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] golden_next(input logic [15:0] v);
    int x;
    int b;
    x = int'(v);
    b = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
    return 16'(((x << 1) | b) & 32'hFFFF);
  endfunction

  task automatic clr_stats();
    run_obs = 0; max_run_obs = 0; n_stall_obs = 0; n_iss0 = 0; n_acc0 = 0;
    saw_full = 1'b0;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic cyc();
    logic          exp_stall;
    logic [CH-1:0] exp_en, exp_rdy, acc, drop;
    @(negedge clk);
    exp_stall = bus.cfg_en && (int'(m_lfsr[7:0]) < int'(bus.cfg_thresh)) && (m_run < MAX_STALL);
    for (int k = 0; k < CH; k++) begin
      exp_rdy[k] = m_pend[k] < PEND_MAX;
      acc[k]     = bus.en_i[k] && exp_rdy[k];
      drop[k]    = bus.en_i[k] && !exp_rdy[k];
      exp_en[k]  = !exp_stall && (m_pend[k] > 0 || acc[k]);
    end
    check("en_o",      32'(bus.en_o),        32'(exp_en));
    check("rdy_o",     32'(bus.rdy_o),       32'(exp_rdy));
    check("stall_o",   32'(bus.stall_o),     32'(exp_stall));
    check("ovf_o",     32'(bus.ovf_o),       32'(m_ovf));
    check("stall_cnt", 32'(bus.stall_cnt_o), 32'(m_cnt));
    check("lfsr",      32'(dut.lfsr_reg),    32'(m_lfsr));
    if (bus.stall_o) begin
      run_obs++;
      n_stall_obs++;
    end else begin
      run_obs = 0;
    end
    if (run_obs > max_run_obs) max_run_obs = run_obs;
    if (bus.en_o[0]) n_iss0++;
    if (acc[0]) n_acc0++;
    if (!bus.rdy_o[0]) saw_full = 1'b1;
    @(posedge clk);
    if (rst) begin
      m_lfsr = 16'hFFFF; m_run = 0; m_ovf = '0; m_cnt = 0;
      for (int k = 0; k < CH; k++) m_pend[k] = 0;
    end else begin
      if (bus.seed_ld) m_lfsr = (bus.seed == 16'h0) ? 16'h0001 : bus.seed;
      else m_lfsr = golden_next(m_lfsr);
      m_run = exp_stall ? m_run + 1 : 0;
      if (exp_stall && m_cnt < 65535) m_cnt++;
      m_ovf = m_ovf | drop;
      for (int k = 0; k < CH; k++) m_pend[k] = m_pend[k] + int'(acc[k]) - int'(exp_en[k]);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    bus.cfg_en = 1'b0; bus.cfg_thresh = 8'h00; bus.seed_ld = 1'b0; bus.seed = '0; bus.en_i = '0;
    m_lfsr = 16'hFFFF; m_run = 0; m_ovf = '0; m_cnt = 0;
    for (int k = 0; k < CH; k++) m_pend[k] = 0;
    @(posedge clk); #1;
    do_reset();

    // first cycle after reset: lfsr low byte is 0xFF so no stall even at max threshold
    bus.cfg_en = 1'b1; bus.cfg_thresh = 8'hFF; bus.en_i = 4'b1010;
    cyc();
    $display("reset: first cycle checked");

    // bypass
    do_reset();
    clr_stats();
    bus.cfg_en = 1'b0; bus.en_i = 4'b1111;
    for (int i = 0; i < 20; i++) cyc();
    check("bypass_stalls", 32'(n_stall_obs), 32'd0);
    check("bypass_issue0", 32'(n_iss0), 32'd20);
    $display("bypass: 20 cycles");

    // stall run bound from seed 0xFFFF
    do_reset();
    clr_stats();
    bus.cfg_en = 1'b1; bus.cfg_thresh = 8'hFF; bus.en_i = '0;
    for (int i = 0; i < 1000; i++) cyc();
    check("max_run_le3", 32'(max_run_obs > MAX_STALL), 32'd0);
    check("stall_cnt_total", 32'(bus.stall_cnt_o), 32'(n_stall_obs));
    $display("bound: 1000 cycles, stalls=%0d longest_run=%0d", n_stall_obs, max_run_obs);

    // backlog on channel 0
    clr_stats();
    bus.en_i = 4'b0001;
    for (int i = 0; i < 40; i++) cyc();
    guard = 0;
    while (m_pend[0] != PEND_MAX && guard < 50) begin
      cyc();
      guard++;
    end
    check("backlog_reached", 32'(m_pend[0]), 32'(PEND_MAX));
    check("backlog_full_seen", 32'(saw_full), 32'd1);
    check("backlog_ovf0", 32'(bus.ovf_o[0]), 32'd1);
    check("backlog_issued", 32'(n_iss0), 32'(n_acc0 - m_pend[0]));
    $display("backlog: accepted=%0d issued=%0d", n_acc0, n_iss0);

    // drain
    clr_stats();
    bus.cfg_en = 1'b0; bus.en_i = '0;
    for (int i = 0; i < 8; i++) cyc();
    check("drain_count", 32'(n_iss0), 32'd4);
    check("drain_rdy0", 32'(bus.rdy_o[0]), 32'd1);
    $display("drain: issued=%0d", n_iss0);

    // seed loading
    bus.seed_ld = 1'b1; bus.seed = 16'h0000;
    cyc();
    bus.seed_ld = 1'b0;
    check("seed_zero", 32'(dut.lfsr_reg), 32'h0001);
    cyc();
    bus.seed_ld = 1'b1; bus.seed = 16'h1234;
    cyc();
    bus.seed_ld = 1'b0;
    check("seed_1234", 32'(dut.lfsr_reg), 32'h1234);
    cyc();
    check("seed_next", 32'(dut.lfsr_reg), 32'(golden_next(16'h1234)));
    $display("seed: loads checked");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.cfg_en     = ($urandom_range(0, 3) != 0);
      bus.cfg_thresh = 8'($urandom);
      bus.en_i       = CH'($urandom);
      bus.seed_ld    = ($urandom_range(0, 49) == 0);
      bus.seed       = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      rst            = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; bus.seed_ld = 1'b0;
    $display("random: 3000 cycles");

    // mid-operation reset with channel 2 backlogged and overflowed
    do_reset();
    bus.cfg_en = 1'b1; bus.cfg_thresh = 8'hFF; bus.en_i = 4'b0100;
    guard = 0;
    while (!(m_pend[2] == 3 && m_ovf[2] && m_cnt > 0) && guard < 300) begin
      cyc();
      guard++;
    end
    check("midrst_setup", 32'(guard < 300), 32'd1);
    bus.en_i = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_ovf", 32'(bus.ovf_o), 32'd0);
    check("midrst_cnt", 32'(bus.stall_cnt_o), 32'd0);
    check("midrst_lfsr", 32'(dut.lfsr_reg), 32'hFFFF);
    clr_stats();
    for (int i = 0; i < 6; i++) cyc();
    check("midrst_no_issue", 32'(bus.en_o), 32'd0);
    $display("midreset: backlog discarded");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
